// File: rtl/common_dl_sched_pkg.sv
// Shared helpers and default sizing for the round-robin scheduled delay line.
// Tagged word layout is {id, data}, with the ID in the upper bits.
package common_dl_sched_pkg;

  localparam int unsigned NB_DATA_DEF   = 8;
  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned DELAY_DEF     = 10;
  localparam int unsigned MAX_OUTST_DEF = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

  function automatic int unsigned nb_id(input int unsigned n_req);
    return (n_req <= 2) ? 1 : clog2(n_req);
  endfunction

  function automatic int unsigned nb_outst(input int unsigned max_outst);
    return clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/common_rr_arbiter.sv
// Round-robin arbiter: first eligible index at or above the pointer, with wrap.
// The pointer moves past the winner on a grant and holds otherwise.
module common_rr_arbiter
  import common_dl_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned NB_ID = nb_id(N_REQ)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [N_REQ-1:0] i_eligible,
  output logic [N_REQ-1:0] o_grant,
  output logic [NB_ID-1:0] o_grant_idx,
  output logic             o_any_grant
);

  logic [NB_ID-1:0] r_ptr;
  logic [NB_ID-1:0] w_ptr_next;
  logic [N_REQ-1:0] w_grant;
  logic [NB_ID-1:0] w_idx;
  logic             w_found;

  always_comb begin
    int unsigned cand;
    cand    = 0;
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(r_ptr) + i) % N_REQ;
      if (!w_found && i_eligible[cand]) begin
        w_grant[cand] = 1'b1;
        w_idx         = NB_ID'(cand);
        w_found       = 1'b1;
      end
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_found) begin
      w_ptr_next = (w_idx == NB_ID'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;
  assign o_any_grant = w_found;

endmodule

// File: rtl/common_delay_line_rr_sched.sv
// Fixed-latency delay line shared by N_REQ requesters via round-robin, with per-requester
// in-flight caps. Optional synchronous flush port enabled by COMMON_DL_SCHED_FLUSH_EN.
module common_delay_line_rr_sched
  import common_dl_sched_pkg::*;
#(
  parameter int unsigned NB_DATA   = NB_DATA_DEF,
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned DELAY     = DELAY_DEF,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF,
  localparam int unsigned NB_ID    = nb_id(N_REQ),
  localparam int unsigned NB_OUTST = nb_outst(MAX_OUTST)
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
`ifdef COMMON_DL_SCHED_FLUSH_EN
  input  logic                     i_flush,
`endif
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_req_grant,
  output logic [NB_DATA-1:0]       o_data_out,
  output logic [NB_ID-1:0]         o_id,
  output logic                     o_valid,
  output logic                     o_busy
);

  typedef struct packed {
    logic [NB_ID-1:0]   id;
    logic [NB_DATA-1:0] data;
  } word_t;

  logic [DELAY-1:0]    r_vld;
  word_t               r_word  [DELAY];
  logic [NB_OUTST-1:0] r_outst [N_REQ];

  logic                w_flush;
  logic [N_REQ-1:0]    w_eligible;
  logic [N_REQ-1:0]    w_retire;
  logic [N_REQ-1:0]    w_grant;
  logic [NB_ID-1:0]    w_grant_idx;
  logic                w_any_grant;

`ifdef COMMON_DL_SCHED_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  // A word retiring this cycle frees its slot in the same cycle, so a capped requester
  // can be re-granted without a bubble. Reset gates eligibility so grants drop at once.
  always_comb begin
    w_retire   = '0;
    w_eligible = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_retire[k]   = r_vld[DELAY-1] && (r_word[DELAY-1].id == NB_ID'(k));
      w_eligible[k] = i_req_valid[k] && i_reset_n && !w_flush &&
                      ((r_outst[k] != NB_OUTST'(MAX_OUTST)) || w_retire[k]);
    end
  end

  common_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_eligible  (w_eligible),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vld <= '0;
      for (int unsigned i = 0; i < DELAY; i++) r_word[i] <= '0;
    end else begin
      r_vld[0] <= w_any_grant && !w_flush;
      if (w_any_grant) begin
        r_word[0] <= '{id: w_grant_idx, data: i_req_data[w_grant_idx*NB_DATA +: NB_DATA]};
      end
      for (int unsigned i = 1; i < DELAY; i++) begin
        r_vld[i] <= r_vld[i-1] && !w_flush;
        if (r_vld[i-1]) r_word[i] <= r_word[i-1];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned k = 0; k < N_REQ; k++) r_outst[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (w_flush) begin
          r_outst[k] <= '0;
        end else if (w_grant[k] && !w_retire[k]) begin
          r_outst[k] <= r_outst[k] + 1'b1;
        end else if (w_retire[k] && !w_grant[k]) begin
          r_outst[k] <= r_outst[k] - 1'b1;
        end
      end
    end
  end

  assign o_req_grant = w_grant;
  assign o_valid     = r_vld[DELAY-1];
  assign o_id        = r_word[DELAY-1].id;
  assign o_data_out  = r_word[DELAY-1].data;
  assign o_busy      = |r_vld;

endmodule

// File: tb/tb_common_delay_line_rr_sched.sv
// Randomized bench for common_delay_line_rr_sched against a queue-based reference model.
// Flush scenario is exercised when COMMON_DL_SCHED_FLUSH_EN is defined.
module tb_common_delay_line_rr_sched;

  localparam int NB_DATA   = 8;
  localparam int N_REQ     = 4;
  localparam int DELAY     = 10;
  localparam int MAX_OUTST = 4;

  logic                     i_clock;
  logic                     i_reset_n;
  logic [N_REQ-1:0]         i_req_valid;
  logic [N_REQ*NB_DATA-1:0] i_req_data;
  logic [N_REQ-1:0]         o_req_grant;
  logic [NB_DATA-1:0]       o_data_out;
  logic [1:0]               o_id;
  logic                     o_valid;
  logic                     o_busy;
`ifdef COMMON_DL_SCHED_FLUSH_EN
  logic                     tb_flush;
`endif

  common_delay_line_rr_sched #(
    .NB_DATA   (NB_DATA),
    .N_REQ     (N_REQ),
    .DELAY     (DELAY),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
`ifdef COMMON_DL_SCHED_FLUSH_EN
    .i_flush     (tb_flush),
`endif
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_grant (o_req_grant),
    .o_data_out  (o_data_out),
    .o_id        (o_id),
    .o_valid     (o_valid),
    .o_busy      (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct {
    int         id;
    logic [7:0] data;
    int         due;
  } ent_t;

  ent_t        q[$];
  int          ptr;
  int          cyc;
  int          n_checks;
  int          n_errors;
  int          grants2;
  logic [3:0]  last_grant;
  logic        last_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic run_cycle(input logic [3:0] v, input logic [31:0] d, input bit flush);
    bit         ret;
    int         cnt[N_REQ];
    int         g;
    int         k;
    logic [3:0] exp_grant;
    @(negedge i_clock);
    i_req_valid = v;
    i_req_data  = d;
`ifdef COMMON_DL_SCHED_FLUSH_EN
    tb_flush = flush;
`endif
    #1;
    ret = (q.size() > 0) && (q[0].due == cyc);
    for (int j = 0; j < N_REQ; j++) cnt[j] = 0;
    foreach (q[j]) cnt[q[j].id]++;
    g = -1;
    if (!flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        k = (ptr + i) % N_REQ;
        if (g < 0 && v[k] && (cnt[k] < MAX_OUTST || (ret && q[0].id == k))) g = k;
      end
    end
    exp_grant = (g >= 0) ? 4'(1 << g) : 4'd0;
    check("grant", 32'(o_req_grant), 32'(exp_grant));
    check("valid", 32'(o_valid), 32'(ret));
    if (ret) begin
      check("id", 32'(o_id), 32'(q[0].id));
      check("data", 32'(o_data_out), 32'(q[0].data));
    end
    check("busy", 32'(o_busy), 32'(q.size() > 0));
    last_grant = o_req_grant;
    last_busy  = o_busy;
    if (o_req_grant[2]) grants2++;
    if (ret) void'(q.pop_front());
    if (flush) q.delete();
    if (g >= 0) begin
      q.push_back('{id: g, data: d[g*8 +: 8], due: cyc + DELAY});
      ptr = (g + 1) % N_REQ;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(4'd0, $urandom, 1'b0);
  endtask

  initial begin
    logic [31:0] spec_data;
    n_checks    = 0;
    n_errors    = 0;
    grants2     = 0;
    cyc         = 0;
    ptr         = 0;
    last_grant  = '0;
    last_busy   = 1'b0;
    spec_data   = 32'hA3A2A1A0;
    i_reset_n   = 1'b0;
    i_req_valid = 4'hF;
    i_req_data  = spec_data;
`ifdef COMMON_DL_SCHED_FLUSH_EN
    tb_flush = 1'b0;
`endif
    #2;
    check("rst_grant", 32'(o_req_grant), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_id", 32'(o_id), 32'd0);
    check("rst_data", 32'(o_data_out), 32'd0);
    repeat (2) @(negedge i_clock);
    i_req_valid = 4'd0;
    i_reset_n   = 1'b1;

    // All requesters valid: rotation 0,1,2,3 and output after DELAY cycles.
    for (int i = 0; i < 16; i++) run_cycle(4'hF, spec_data, 1'b0);
    idle(DELAY + 2);

    // Requester 2 alone: 4 grants per DELAY-cycle window.
    grants2 = 0;
    for (int i = 0; i < DELAY; i++) run_cycle(4'b0100, $urandom, 1'b0);
    check("thr_first_window", 32'(grants2), 32'd4);
    for (int i = 0; i < 2 * DELAY; i++) run_cycle(4'b0100, $urandom, 1'b0);
    check("thr_steady", 32'(grants2), 32'd12);
    idle(DELAY + 2);

    // Sparse random traffic with random data.
    for (int i = 0; i < 300; i++) run_cycle(4'($urandom & $urandom), $urandom, 1'b0);
    idle(DELAY + 2);

    // Requester 1 at MAX_OUTST-1, re-granted in the cycle its first word retires.
    for (int i = 0; i < MAX_OUTST - 1; i++) run_cycle(4'b0010, $urandom, 1'b0);
    idle(DELAY - (MAX_OUTST - 1));
    run_cycle(4'b0010, $urandom, 1'b0);
    check("gr_ret_grant", 32'(last_grant), 32'b0010);
    check("gr_ret_busy", 32'(last_busy), 32'd1);
    for (int i = 0; i < 12; i++) run_cycle(4'b0010, $urandom, 1'b0);
    idle(DELAY + 2);

    // Mid-stream reset with 7 words in flight.
    for (int i = 0; i < 7; i++) run_cycle(4'hF, $urandom, 1'b0);
    @(posedge i_clock);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_grant", 32'(o_req_grant), 32'd0);
    @(negedge i_clock);
    i_req_valid = 4'd0;
    i_reset_n   = 1'b1;
    q.delete();
    ptr = 0;
    run_cycle(4'hF, $urandom, 1'b0);
    check("post_rst_first", 32'(last_grant), 32'b0001);
    for (int i = 0; i < 20; i++) run_cycle(4'($urandom), $urandom, 1'b0);
    idle(DELAY + 2);

`ifdef COMMON_DL_SCHED_FLUSH_EN
    // Flush with 5 words in flight: no grant that cycle, pipeline and counters clear.
    for (int i = 0; i < 5; i++) run_cycle(4'hF, $urandom, 1'b0);
    run_cycle(4'hF, $urandom, 1'b1);
    check("flush_grant", 32'(last_grant), 32'd0);
    run_cycle(4'd0, $urandom, 1'b0);
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_busy", 32'(last_busy), 32'd0);
    for (int i = 0; i < 20; i++) run_cycle(4'hF, $urandom, 1'b0);
    idle(DELAY + 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
